mul4_seq: RTL and testbench
===========================

# mul4_seq

Sequential 4×4 unsigned shift-and-add multiplier built around the team's 4-bit ripple-carry adder. It sits directly upstream of that adder: it supplies operands from its internal registers each cycle, consumes the 4-bit sum and carry-out, and folds them into a shifting partial product. The product is ready after four add/shift cycles, and a start/busy/done handshake lets lab top-levels (switch inputs, LED outputs) sequence operations.

## Interface
- N, 4, operand width; only 4 is supported because the adder is fixed at 4 bits.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  4  multiplicand, unsigned; captured on the accept edge.
- b  input  4  multiplier, unsigned; captured on the accept edge.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse, high while in DONE.
- p  output  8  product; registered and held until the next completion.

## Operation
- **Registers**
  - m[3:0]: multiplicand.
  - q[3:0]: multiplier, which becomes the low half of the product.
  - acc[3:0]: upper partial product.
  - cnt[1:0]: step counter.
  - state.
- **IDLE**
  - start=1: load m←a, q←b, acc←0, cnt←0; go to CALC.
  - start=0: stay in IDLE.
- **CALC**, one step per cycle:
  - If q[0]=1: adder inputs are (acc, m), carry-in 0; {c,s} = {cout,sum}.
  - If q[0]=0: s=acc, c=0. The adder still evaluates, but its result is ignored.
  - Shift right: acc←{c,s[3:1]}, q←{s[0],q[3:1]}, cnt←cnt+1.
  - When cnt=3 this step is the fourth: also load p←{c,s[3:1],s[0],q[3:1]} (the post-shift {acc,q}) and go to DONE.
- **DONE**
  - done=1 for this cycle only.
  - Unconditionally go to IDLE.
  - start is ignored in this state.
- **Width rules**
  - All arithmetic is unsigned.
  - The 8-bit product never overflows, since 15×15=225.
  - The adder carry-in is always tied 0; the block never relies on it.
- **Isolation and hold**
  - Changes on a or b after the accept edge have no effect on the result.
  - p changes only on the CALC→DONE edge (and on reset).

## Timing
- **Reset** (synchronous; wins over every other event, including start and mid-CALC):
  - state=IDLE, busy=0, done=0, p=8'h00.
  - m, q, acc, cnt are cleared.
  - Any in-flight operation is discarded; no done pulse follows.
- **Latency**, with start accepted at edge E:
  - busy=1 from E to E+4.
  - Four steps at edges E+1 through E+4; DONE is entered and p is updated at E+4.
  - done=1 during cycle (E+4, E+5).
  - IDLE at E+5.
  - Earliest next accept is E+6, giving a throughput of one product per 6 cycles.
- **Handshake**
  - start held high continuously produces back-to-back operations at 6-cycle spacing.
  - A start pulse arriving while busy or in DONE is dropped, not queued.
- **Combinational paths**
  - The adder path is combinational within one cycle: m/acc registers → ripple adder → acc/q registers.
  - No output is combinational from any input.

## Structure
- **Shared package mul_pkg**
  - N=4.
  - State encoding IDLE=2'b00, CALC=2'b01, DONE=2'b10; 2'b11 is unused and decodes to IDLE.
  - STEPS=4.
- **Sub-module**
  - Exactly one instance of the team's 4-bit ripple-carry adder, fa4, with carry-in tied 1'b0.
  - No other sub-modules; the datapath registers and FSM live in mul4_seq.

## Test plan
- **Reset then idle:** reset high 2 cycles, then low, start=0 → busy=0, done=0, p=8'h00 held for 10 cycles.
- **Products:** a=4'hF, b=4'hF, 1-cycle start → done pulse exactly 4 edges after accept edge, p=8'hE1; repeat with a=12, b=10 → p=8'h78; a=9, b=0 → p=8'h00; a=1, b=1 → p=8'h01.
- **Operand isolation:** accept a=3, b=5, then change a=15, b=15 during CALC → p=8'h0F.
- **Dropped start:** pulse start again during CALC and again in DONE → ignored; exactly one done; busy returns 0 and stays 0.
- **Continuous start:** start held high with a=7, b=6 → done pulses every 6 cycles, p=8'h2A each time.
- **Reset mid-operation:** reset asserted at second CALC step → next cycle IDLE, busy=0, p=8'h00, no done; fresh start a=2, b=3 → p=8'h06.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential 4x4 shift-and-add multiplier.
package mul_pkg;

  localparam int N     = 4;
  localparam int STEPS = 4;

  // 2'b11 is never produced and falls back to IDLE behaviour in the FSM
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/fa4.sv
// Team 4-bit ripple-carry adder: sum/cout from a, b and carry-in.
module fa4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic carry_s;

  // Ripple the carry through four full-adder cells
  always_comb begin
    carry_s = cin;
    sum     = 4'h0;
    for (int i = 0; i < 4; i++) begin
      sum[i]  = a[i] ^ b[i] ^ carry_s;
      carry_s = (a[i] & b[i]) | (carry_s & (a[i] ^ b[i]));
    end
    cout = carry_s;
  end

endmodule

// File: rtl/mul4_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier with start/busy/done handshake.
// One add/shift step per cycle through a single fa4; product registered in p.
module mul4_seq
  import mul_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  localparam logic [1:0] LAST_STEP = 2'(STEPS - 1);

  state_t         state_r;
  logic [N-1:0]   m_r;
  logic [N-1:0]   q_r;
  logic [N-1:0]   acc_r;
  logic [1:0]     cnt_r;

  logic [N-1:0]   sum_s;
  logic           cout_s;
  logic [N-1:0]   s_s;
  logic           c_s;

  fa4 u_fa4 (
    .a    (acc_r),
    .b    (m_r),
    .cin  (1'b0),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // Select adder result or pass-through accumulator depending on multiplier LSB
  always_comb begin
    s_s = acc_r;
    c_s = 1'b0;
    if (q_r[0]) begin
      s_s = sum_s;
      c_s = cout_s;
    end else begin
      s_s = acc_r;
      c_s = 1'b0;
    end
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      m_r     <= 4'h0;
      q_r     <= 4'h0;
      acc_r   <= 4'h0;
      cnt_r   <= 2'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      p       <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m_r     <= a;
            q_r     <= b;
            acc_r   <= 4'h0;
            cnt_r   <= 2'd0;
            busy    <= 1'b1;
            state_r <= CALC;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        CALC: begin
          acc_r <= {c_s, s_s[3:1]};
          q_r   <= {s_s[0], q_r[3:1]};
          cnt_r <= cnt_r + 2'd1;
          // Fourth step: the post-shift {acc,q} is the finished product
          if (cnt_r == LAST_STEP) begin
            p       <= {c_s, s_s[3:1], s_s[0], q_r[3:1]};
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            busy    <= 1'b1;
            done    <= 1'b0;
            state_r <= CALC;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul4_seq.sv
// Directed self-checking bench for mul4_seq: handshake timing, products, isolation, reset.
module tb_mul4_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] p;

  int checks;
  int errors;
  logic [7:0] last_p;

  mul4_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    a = 4'h0;
    b = 4'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || p !== 8'h00) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: busy=%b done=%b p=%h, want busy=0 done=0 p=00", i, busy, done, p);
      end
    end
    last_p = 8'h00;
  endtask

  // Accept one operation, check busy/done timing and the product
  task automatic test_product(input logic [3:0] ta, input logic [3:0] tb_v,
                              input logic [7:0] exp, input string name);
    a = ta;
    b = tb_v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || p !== last_p) begin
        errors++;
        $display("FAIL %s calc k=%0d: busy=%b done=%b p=%h, want busy=1 done=0 p=%h", name, k, busy, done, p, last_p);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || p !== exp) begin
      errors++;
      $display("FAIL %s done: done=%b busy=%b p=%h, want done=1 busy=0 p=%h", name, done, busy, p, exp);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || p !== exp) begin
      errors++;
      $display("FAIL %s after: done=%b busy=%b p=%h, want done=0 busy=0 p=%h", name, done, busy, p, exp);
    end
    last_p = exp;
  endtask

  task automatic test_isolation();
    a = 4'd3;
    b = 4'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 4'd15;
    b = 4'd15;
    repeat (4) @(negedge clk);
    checks++;
    if (done !== 1'b1 || p !== 8'h0F) begin
      errors++;
      $display("FAIL isolation: done=%b p=%h, want done=1 p=0f", done, p);
    end
    @(negedge clk);
    last_p = 8'h0F;
  endtask

  task automatic test_dropped_start();
    int ndone;
    ndone = 0;
    a = 4'd3;
    b = 4'd4;
    start = 1'b1;
    @(negedge clk);          // after accept edge E
    start = 1'b0;
    @(negedge clk);          // after E+1, in CALC
    start = 1'b1;
    @(negedge clk);          // after E+2
    start = 1'b0;
    @(negedge clk);          // after E+3
    @(negedge clk);          // after E+4, in DONE
    if (done === 1'b1) ndone++;
    checks++;
    if (p !== 8'h0C) begin
      errors++;
      $display("FAIL dropped_product: p=%h, want 0c", p);
    end
    start = 1'b1;            // sampled while in DONE
    @(negedge clk);          // after E+5, back in IDLE
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) ndone++;
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL dropped_busy cycle %0d: busy=%b, want 0", i, busy);
      end
      @(negedge clk);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL dropped_done_count: got %0d pulses, want 1", ndone);
    end
    last_p = 8'h0C;
  endtask

  task automatic test_back_to_back();
    a = 4'd7;
    b = 4'd6;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);        // after edge E+i
      checks++;
      if (done !== ((i % 6) == 4)) begin
        errors++;
        $display("FAIL b2b_done i=%0d: done=%b, want %b", i, done, ((i % 6) == 4));
      end
      if ((i % 6) == 4) begin
        checks++;
        if (p !== 8'h2A) begin
          errors++;
          $display("FAIL b2b_product i=%0d: p=%h, want 2a", i, p);
        end
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b done=%b, want 0 0", busy, done);
    end
    last_p = 8'h2A;
  endtask

  task automatic test_reset_mid();
    a = 4'd9;
    b = 4'd5;
    start = 1'b1;
    @(negedge clk);          // after accept edge E
    start = 1'b0;
    @(negedge clk);          // after first step
    reset = 1'b1;            // hits second step edge
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || p !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b p=%h, want 0 0 00", busy, done, p);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet cycle %0d: busy=%b done=%b, want 0 0", i, busy, done);
      end
    end
    last_p = 8'h00;
    test_product(4'd2, 4'd3, 8'h06, "after_reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_p = 8'h00;
    reset = 1'b1;
    start = 1'b0;
    a = 4'h0;
    b = 4'h0;
    @(negedge clk);
    test_reset();
    test_product(4'hF, 4'hF, 8'hE1, "p_15x15");
    test_product(4'd12, 4'd10, 8'h78, "p_12x10");
    test_product(4'd9, 4'd0, 8'h00, "p_9x0");
    test_product(4'd1, 4'd1, 8'h01, "p_1x1");
    test_isolation();
    test_dropped_start();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
